// File: rtl/avalon_bus_down_sizer.sv
// Splits one 512-bit wait-state Avalon-MM slave access into four 128-bit pipelined master beats.
// Optional macro DOWNSIZER_SKIP_EMPTY_BEAT_EN: write beats whose byte-enable slice is all-zero are skipped.

module avalon_bus_down_sizer #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] SlaveAddr_i,
    input  logic              SlaveRead_i,
    input  logic              SlaveWrite_i,
    input  logic [63:0]       SlaveByteEnable_i,
    input  logic [511:0]      SlaveWriteData_i,
    output logic [511:0]      SlaveReadData_o,
    output logic              SlaveWaitReq_o,
    output logic [63:0]       MasterAddr_o,
    output logic              MasterRead_o,
    output logic              MasterWrite_o,
    output logic [15:0]       MasterByteEnable_o,
    output logic [127:0]      MasterWriteData_o,
    input  logic [127:0]      MasterReadData_i,
    input  logic              MasterReadDataValid_i,
    input  logic              MasterWaitReq_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    state_t            r_state, w_stateNext;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_be;
    logic [511:0]      r_wd;
    logic              r_isWr;
    logic [1:0]        r_beat, w_beatNext;
    logic [2:0]        r_rdCnt, w_rdCntNext;
    logic [511:0]      r_rdQ, w_rdQNext;
    logic [511:0]      r_rdOut;
    logic              w_load, w_capture, w_accept, w_rdDone;

`ifdef DOWNSIZER_SKIP_EMPTY_BEAT_EN
    logic [2:0] w_firstIdx, w_nextIdx;

    // Returns the lowest beat >= start with a non-empty BE slice, or 4 if none remain.
    function automatic logic [2:0] firstBeat(input logic [63:0] be, input logic [2:0] start);
        logic [2:0] idx;
        idx = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(start) && (|be[i*16 +: 16])) idx = 3'(i);
        end
        return idx;
    endfunction

    assign w_firstIdx = firstBeat(SlaveByteEnable_i, 3'd0);
    assign w_nextIdx  = firstBeat(r_be, {1'b0, r_beat} + 3'd1);
`endif

    assign w_accept    = (r_state == ISSUE) && !MasterWaitReq_i;
    assign w_capture   = MasterReadDataValid_i && (r_state == ISSUE || r_state == WAIT_RD)
                         && (r_rdCnt != 3'd4);
    assign w_rdCntNext = r_rdCnt + {2'b00, w_capture};

    always_comb begin
        w_rdQNext = r_rdQ;
        if (w_capture) w_rdQNext[{r_rdCnt[1:0], 7'd0} +: 128] = MasterReadData_i;
    end

    // Read completion uses the post-capture count so the slave is released L+1 cycles after beat 3.
    always_comb begin
        w_stateNext = r_state;
        w_beatNext  = r_beat;
        w_load      = 1'b0;
        w_rdDone    = 1'b0;
        case (r_state)
            IDLE: begin
                if (SlaveWrite_i || SlaveRead_i) begin
                    w_load      = 1'b1;
                    w_stateNext = ISSUE;
                    w_beatNext  = 2'd0;
`ifdef DOWNSIZER_SKIP_EMPTY_BEAT_EN
                    if (SlaveWrite_i) begin
                        if (w_firstIdx[2]) w_stateNext = DONE;
                        else               w_beatNext  = w_firstIdx[1:0];
                    end
`endif
                end
            end
            ISSUE: begin
                if (w_accept) begin
                    if (r_isWr) begin
`ifdef DOWNSIZER_SKIP_EMPTY_BEAT_EN
                        if (w_nextIdx[2]) w_stateNext = DONE;
                        else              w_beatNext  = w_nextIdx[1:0];
`else
                        if (r_beat == 2'd3) w_stateNext = DONE;
                        else                w_beatNext  = r_beat + 2'd1;
`endif
                    end else if (r_beat == 2'd3) begin
                        w_rdDone    = (w_rdCntNext == 3'd4);
                        w_stateNext = w_rdDone ? DONE : WAIT_RD;
                    end else begin
                        w_beatNext = r_beat + 2'd1;
                    end
                end
            end
            WAIT_RD: begin
                if (w_rdCntNext == 3'd4) begin
                    w_rdDone    = 1'b1;
                    w_stateNext = DONE;
                end
            end
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_stateNext;
    end

    // r_rdOut is only refreshed when a read completes, so it holds across writes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr  <= '0;
            r_be    <= '0;
            r_wd    <= '0;
            r_isWr  <= 1'b0;
            r_beat  <= 2'd0;
            r_rdCnt <= 3'd0;
            r_rdQ   <= '0;
            r_rdOut <= '0;
        end else begin
            r_beat  <= w_beatNext;
            r_rdCnt <= w_load ? 3'd0 : w_rdCntNext;
            r_rdQ   <= w_rdQNext;
            if (w_load) begin
                r_addr <= SlaveAddr_i;
                r_be   <= SlaveByteEnable_i;
                r_wd   <= SlaveWriteData_i;
                r_isWr <= SlaveWrite_i;
            end
            if (w_rdDone) r_rdOut <= w_rdQNext;
        end
    end

    assign SlaveWaitReq_o     = (r_state != DONE);
    assign SlaveReadData_o    = r_rdOut;
    assign MasterRead_o       = (r_state == ISSUE) && !r_isWr;
    assign MasterWrite_o      = (r_state == ISSUE) && r_isWr;
    assign MasterAddr_o       = {{(62-ADDR_W){1'b0}}, r_addr, r_beat};
    assign MasterByteEnable_o = r_be[{r_beat, 4'd0} +: 16];
    assign MasterWriteData_o  = r_wd[{r_beat, 7'd0} +: 128];

endmodule
